aes_round_ctrl: RTL
===================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, meaning AES-128 round count; only 10 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_valid  input  1  input block offered.
REQ-005 SHALL have port o_ready  output  1  controller can accept a block.
REQ-006 SHALL have port i_data  input  128  plaintext block.
REQ-007 SHALL have port i_key  input  128  round key selected by o_key_idx.
REQ-008 SHALL have port o_key_idx  output  4  index of the round key requested, 0..10.
REQ-009 SHALL have port o_dp_data  output  128  state fed to the round datapath (sub_bytes/shift_rows/mix_columns/add_round_key).
REQ-010 SHALL have port i_dp_data  input  128  round datapath result.
REQ-011 SHALL have port o_mc_state  output  5  round state driven to the mix_columns i_state input.
REQ-012 SHALL have port o_valid  output  1  ciphertext available.
REQ-013 SHALL have port i_ready  input  1  consumer accepts ciphertext.
REQ-014 SHALL have port o_data  output  128  ciphertext.
REQ-015 SHALL have port o_busy  output  1  high in ROUND and DONE.

Function
REQ-016 SHALL implement the FSM states IDLE, ROUND and DONE.
REQ-017 In IDLE: o_ready=1, o_key_idx=0, o_mc_state=0; on i_valid&&o_ready, state_reg<=i_data^i_key, round<=0, next state ROUND.
REQ-018 In ROUND: o_dp_data=state_reg, o_key_idx=round+1, o_mc_state={1'b0,round}; each cycle state_reg<=i_dp_data.
REQ-019 In ROUND: if round==NUM_ROUNDS-1 (4'd9), next state DONE; else round<=round+1.
REQ-020 o_mc_state SHALL equal 5'b01001 only in the final round, so mix_columns bypass occurs exactly once per block.
REQ-021 In DONE: o_valid=1, o_data=state_reg; on i_ready, next state IDLE; o_data SHALL remain stable while o_valid&&!i_ready.
REQ-022 o_ready SHALL be 0 outside IDLE; a new block is never accepted in the cycle DONE completes; throughput is 1 block per 12 cycles minimum.
REQ-023 Latency: o_valid SHALL first rise 11 rising edges after the acceptance edge (1 load + 10 rounds).
REQ-024 round SHALL be 4 bits and SHALL never exceed 9; no wrap-around occurs.
REQ-025 o_data SHALL be 0 outside DONE, and o_dp_data SHALL be 0 outside ROUND.

Reset
REQ-026 On rst=1 at a clock edge: state<=IDLE, round<=0, state_reg<=0; any in-flight block is discarded.
REQ-027 Outputs after reset: o_ready=1, o_valid=0, o_busy=0, o_key_idx=0, o_mc_state=0, o_data=0, o_dp_data=0.
REQ-028 rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-029 SHALL support macro AES_CTRL_KEY_WAIT_EN.
REQ-030 With AES_CTRL_KEY_WAIT_EN defined: add port i_key_valid input 1; IDLE acceptance additionally requires i_key_valid; in ROUND, while !i_key_valid, state_reg and round SHALL hold and o_key_idx SHALL stay constant.
REQ-031 Without AES_CTRL_KEY_WAIT_EN: port i_key_valid absent; keys are always valid; latency is fixed per REQ-023.

Structure
REQ-032 Package aes_pkg SHALL hold the FSM state enum typedef, AES_NUM_ROUNDS=10, AES_FINAL_ROUND_IDX=4'd9 and the 128-bit block typedef.
REQ-033 Round counter SHALL be sub-module aes_round_counter (clear, enable, 4-bit count, last flag).

Verification
REQ-034 FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> o_data 3925841d02dc09fbdc118597196a0b32, o_valid 11 edges after accept.
REQ-035 Sweep o_key_idx 1..10 in consecutive ROUND cycles; o_mc_state=9 exactly one cycle per block.
REQ-036 Hold i_ready=0 for 5 cycles in DONE -> o_valid and o_data stable; i_ready=1 -> IDLE, o_ready=1 next cycle.
REQ-037 Assert rst during round 5 -> next cycle IDLE, all outputs at reset values; a subsequent block produces correct ciphertext.
REQ-038 With AES_CTRL_KEY_WAIT_EN: drop i_key_valid for 3 cycles at round 4 -> round/o_key_idx held, result still correct, latency 14.
REQ-039 Hold i_valid=1 continuously -> blocks accepted only in IDLE, 12 cycles apart.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES-128 round controller.
package aes_pkg;
    localparam int         AES_NUM_ROUNDS      = 10;
    localparam logic [3:0] AES_FINAL_ROUND_IDX = 4'd9;
    typedef logic [127:0] aes_block_t;
    typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;
endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: block handshake, key request and round datapath signals.
// AES_CTRL_KEY_WAIT_EN adds i_key_valid.
interface aes_round_ctrl_if;
    import aes_pkg::*;
    logic       i_valid;
    logic       o_ready;
    aes_block_t i_data;
    aes_block_t i_key;
    logic [3:0] o_key_idx;
    aes_block_t o_dp_data;
    aes_block_t i_dp_data;
    logic [4:0] o_mc_state;
    logic       o_valid;
    logic       i_ready;
    aes_block_t o_data;
    logic       o_busy;
`ifdef AES_CTRL_KEY_WAIT_EN
    logic       i_key_valid;
`endif
    modport slave (
`ifdef AES_CTRL_KEY_WAIT_EN
        input  i_key_valid,
`endif
        input  i_valid, i_data, i_key, i_dp_data, i_ready,
        output o_ready, o_key_idx, o_dp_data, o_mc_state, o_valid, o_data, o_busy
    );
    modport master (
`ifdef AES_CTRL_KEY_WAIT_EN
        output i_key_valid,
`endif
        output i_valid, i_data, i_key, i_dp_data, i_ready,
        input  o_ready, o_key_idx, o_dp_data, o_mc_state, o_valid, o_data, o_busy
    );
endinterface

// File: rtl/aes_round_counter.sv
// aes_round_counter: round index 0..LAST with synchronous clear; saturates at LAST.
module aes_round_counter import aes_pkg::*; #(
    parameter logic [3:0] LAST = AES_FINAL_ROUND_IDX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [3:0] cnt_o,
    output logic       last_o
);
    logic [3:0] cnt_q, cnt_d;
    assign last_o = cnt_q == LAST;
    assign cnt_o  = cnt_q;
    always_comb cnt_d = clr_i ? 4'd0 : (en_i && !last_o) ? cnt_q + 4'd1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= rst ? 4'd0 : cnt_d;
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128 sequencer (IDLE -> 10 x ROUND -> DONE) around an external round datapath.
// Define AES_CTRL_KEY_WAIT_EN to stall loading and rounds until i_key_valid.
module aes_round_ctrl import aes_pkg::*; #(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input logic             clk,
    input logic             rst,
    aes_round_ctrl_if.slave bus
);
    aes_state_e state_q, state_d;
    aes_block_t blk_q, blk_d;
    logic [3:0] round;
    logic       clr, en, last, key_ok, in_round;
`ifdef AES_CTRL_KEY_WAIT_EN
    assign key_ok = bus.i_key_valid;
`else
    assign key_ok = 1'b1;
`endif
    aes_round_counter #(.LAST(4'(NUM_ROUNDS - 1))) u_cnt (
        .clk, .rst, .clr_i(clr), .en_i(en), .cnt_o(round), .last_o(last)
    );
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        clr     = 1'b0;
        en      = 1'b0;
        unique case (state_q)
            IDLE: if (bus.i_valid && key_ok) begin
                blk_d   = bus.i_data ^ bus.i_key;
                clr     = 1'b1;
                state_d = ROUND;
            end
            ROUND: if (key_ok) begin
                blk_d   = bus.i_dp_data;
                en      = 1'b1;
                state_d = last ? DONE : ROUND;
            end
            DONE:    state_d = bus.i_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
        end
    end
    // Outputs are masked to zero outside the state that owns them.
    assign in_round       = state_q == ROUND;
    assign bus.o_ready    = state_q == IDLE;
    assign bus.o_valid    = state_q == DONE;
    assign bus.o_busy     = !bus.o_ready;
    assign bus.o_data     = bus.o_valid ? blk_q : '0;
    assign bus.o_dp_data  = in_round ? blk_q : '0;
    assign bus.o_key_idx  = in_round ? round + 4'd1 : 4'd0;
    assign bus.o_mc_state = in_round ? {1'b0, round} : 5'd0;
endmodule
